timer_sched_ctrl: RTL and testbench

Controller that sits between the CPU I/O bus and the 8-bit register port of the system timer. It programs the timer for a periodic, interrupt-driven system tick and services each tick interrupt by clearing the timer's match status. On every tick it selects the next runnable task round-robin and emits a preemption pulse to the CPU. It also shares the timer's single register port between its own sequencer and direct CPU accesses.

---
 rtl/timer_sched_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_timer_sched_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sched_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : timer_sched_ctrl                                                |
// | Brief   : Programs the system timer for a periodic tick, acknowledges     |
// |           each tick, dispatches tasks round-robin and shares the timer    |
// |           register port with the CPU. Define TSC_CPU_ARB_EN to enable the |
// |           CPU pass-through and arbitration.                               |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module timer_sched_ctrl #(
    parameter int          NUM_TASKS   = 4,
    parameter logic [15:0] TICK_PERIOD = 16'd1000,
    parameter logic [7:0]  PRESCALE    = 8'd99
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic [NUM_TASKS-1:0]         task_mask,
    input  logic                         cpu_req,
    input  logic                         cpu_write,
    input  logic                         cpu_read,
    input  logic [2:0]                   cpu_addr,
    input  logic [7:0]                   cpu_wdata,
    output logic                         cpu_gnt,
    output logic [7:0]                   cpu_rdata,
    output logic                         tmr_cs,
    output logic                         tmr_write,
    output logic                         tmr_read,
    output logic [2:0]                   tmr_addr,
    output logic [7:0]                   tmr_wdata,
    input  logic [7:0]                   tmr_rdata,
    input  logic                         tmr_irq,
    output logic [$clog2(NUM_TASKS)-1:0] task_id,
    output logic                         preempt,
    output logic [31:0]                  tick_count,
    output logic                         busy
);

    localparam int c_TW = $clog2(NUM_TASKS);

    localparam logic [3:0] c_IDLE  = 4'd0;
    localparam logic [3:0] c_I_RST = 4'd1;
    localparam logic [3:0] c_I_PRE = 4'd2;
    localparam logic [3:0] c_I_CL  = 4'd3;
    localparam logic [3:0] c_I_CH  = 4'd4;
    localparam logic [3:0] c_I_GO  = 4'd5;
    localparam logic [3:0] c_RUN   = 4'd6;
    localparam logic [3:0] c_ACK   = 4'd7;
    localparam logic [3:0] c_SCHED = 4'd8;
    localparam logic [3:0] c_HALT  = 4'd9;

    localparam logic [2:0] c_ADDR_CTRL   = 3'd0;
    localparam logic [2:0] c_ADDR_STATUS = 3'd1;
    localparam logic [2:0] c_ADDR_COMP_L = 3'd4;
    localparam logic [2:0] c_ADDR_COMP_H = 3'd5;
    localparam logic [2:0] c_ADDR_PRESC  = 3'd6;

    logic [3:0]      r_state;
    logic [3:0]      w_next_state;
    logic            r_stop_pend;
    logic            w_stop_latch;
    logic [c_TW-1:0] r_task_id;
    logic            r_preempt;
    logic [31:0]     r_tick_count;

    logic            w_seq_wr;
    logic [2:0]      w_seq_addr;
    logic [7:0]      w_seq_data;
    logic            w_cpu_gnt;

    logic            w_found;
    logic [c_TW-1:0] w_next_task;
    logic [c_TW:0]   w_cand;

    // A stop seen mid-sequence is remembered until the controller would otherwise return to RUN.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_I_RST;
            c_I_RST: w_next_state = c_I_PRE;
            c_I_PRE: w_next_state = c_I_CL;
            c_I_CL:  w_next_state = c_I_CH;
            c_I_CH:  w_next_state = c_I_GO;
            c_I_GO:  w_next_state = (r_stop_pend || stop) ? c_HALT : c_RUN;
            c_RUN: begin
                if (tmr_irq)
                    w_next_state = c_ACK;
                else if (stop)
                    w_next_state = c_HALT;
            end
            c_ACK:   w_next_state = c_SCHED;
            c_SCHED: w_next_state = (r_stop_pend || stop) ? c_HALT : c_RUN;
            c_HALT:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    assign w_stop_latch = stop && (r_state != c_IDLE) && (r_state != c_HALT);

    always_comb begin
        w_seq_wr   = 1'b0;
        w_seq_addr = 3'd0;
        w_seq_data = 8'd0;
        case (r_state)
            c_I_RST: begin w_seq_wr = 1'b1; w_seq_addr = c_ADDR_CTRL;   w_seq_data = 8'h08; end
            c_I_PRE: begin w_seq_wr = 1'b1; w_seq_addr = c_ADDR_PRESC;  w_seq_data = PRESCALE; end
            c_I_CL:  begin w_seq_wr = 1'b1; w_seq_addr = c_ADDR_COMP_L; w_seq_data = TICK_PERIOD[7:0]; end
            c_I_CH:  begin w_seq_wr = 1'b1; w_seq_addr = c_ADDR_COMP_H; w_seq_data = TICK_PERIOD[15:8]; end
            c_I_GO:  begin w_seq_wr = 1'b1; w_seq_addr = c_ADDR_CTRL;   w_seq_data = 8'h07; end
            c_ACK:   begin w_seq_wr = 1'b1; w_seq_addr = c_ADDR_STATUS; w_seq_data = 8'h01; end
            c_HALT:  begin w_seq_wr = 1'b1; w_seq_addr = c_ADDR_CTRL;   w_seq_data = 8'h00; end
            default: begin w_seq_wr = 1'b0; end
        endcase
    end

    // Circular search starting one above the current task; wraps back onto itself last.
    always_comb begin
        w_found     = 1'b0;
        w_next_task = r_task_id;
        w_cand      = '0;
        for (int k = 1; k <= NUM_TASKS; k++) begin
            w_cand = {1'b0, r_task_id} + (c_TW+1)'(k);
            if (w_cand >= (c_TW+1)'(NUM_TASKS))
                w_cand = w_cand - (c_TW+1)'(NUM_TASKS);
            if (!w_found && task_mask[w_cand[c_TW-1:0]]) begin
                w_found     = 1'b1;
                w_next_task = w_cand[c_TW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_stop_pend  <= 1'b0;
            r_task_id    <= '0;
            r_preempt    <= 1'b0;
            r_tick_count <= 32'd0;
        end else begin
            r_state <= w_next_state;

            if (w_next_state == c_HALT)
                r_stop_pend <= 1'b0;
            else if (w_stop_latch)
                r_stop_pend <= 1'b1;

            if (r_state == c_ACK)
                r_tick_count <= r_tick_count + 32'd1;

            r_preempt <= 1'b0;
            if (r_state == c_SCHED && w_found) begin
                r_task_id <= w_next_task;
                r_preempt <= 1'b1;
            end
        end
    end

    assign task_id    = r_task_id;
    assign preempt    = r_preempt;
    assign tick_count = r_tick_count;
    assign busy       = (r_state != c_IDLE) && (r_state != c_RUN);

`ifdef TSC_CPU_ARB_EN
    // The CPU only gets the port while the sequencer is quiet and no tick is about to be serviced.
    assign w_cpu_gnt = cpu_req && ((r_state == c_IDLE) || ((r_state == c_RUN) && !tmr_irq));
    assign cpu_rdata = (w_cpu_gnt && cpu_read) ? tmr_rdata : 8'd0;
`else
    logic w_unused_cpu;
    assign w_cpu_gnt    = 1'b0;
    assign cpu_rdata    = 8'd0;
    assign w_unused_cpu = ^{cpu_req, cpu_write, cpu_read, cpu_addr, cpu_wdata, tmr_rdata};
`endif
    assign cpu_gnt = w_cpu_gnt;

    always_comb begin
        tmr_cs    = 1'b0;
        tmr_write = 1'b0;
        tmr_read  = 1'b0;
        tmr_addr  = 3'd0;
        tmr_wdata = 8'd0;
        if (w_seq_wr) begin
            tmr_cs    = 1'b1;
            tmr_write = 1'b1;
            tmr_addr  = w_seq_addr;
            tmr_wdata = w_seq_data;
        end
`ifdef TSC_CPU_ARB_EN
        else if (w_cpu_gnt) begin
            tmr_cs    = 1'b1;
            tmr_write = cpu_write;
            tmr_read  = cpu_read;
            tmr_addr  = cpu_addr;
            tmr_wdata = cpu_wdata;
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_sched_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_timer_sched_ctrl                                             |
// | Brief   : Self-checking bench for timer_sched_ctrl with a task-level      |
// |           scheduler model and randomized ticks / CPU accesses.            |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_timer_sched_ctrl;

    localparam int          NT = 4;
    localparam logic [15:0] TP = 16'd1000;
    localparam logic [7:0]  PS = 8'd99;
`ifdef TSC_CPU_ARB_EN
    localparam bit ARB = 1'b1;
`else
    localparam bit ARB = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start, stop;
    logic [NT-1:0] task_mask;
    logic          cpu_req, cpu_write, cpu_read;
    logic [2:0]    cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_gnt;
    logic [7:0]    cpu_rdata;
    logic          tmr_cs, tmr_write, tmr_read;
    logic [2:0]    tmr_addr;
    logic [7:0]    tmr_wdata;
    logic [7:0]    tmr_rdata;
    logic          tmr_irq;
    logic [1:0]    task_id;
    logic          preempt;
    logic [31:0]   tick_count;
    logic          busy;

    timer_sched_ctrl #(
        .NUM_TASKS   (NT),
        .TICK_PERIOD (TP),
        .PRESCALE    (PS)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .task_mask  (task_mask),
        .cpu_req    (cpu_req),
        .cpu_write  (cpu_write),
        .cpu_read   (cpu_read),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rdata  (cpu_rdata),
        .tmr_cs     (tmr_cs),
        .tmr_write  (tmr_write),
        .tmr_read   (tmr_read),
        .tmr_addr   (tmr_addr),
        .tmr_wdata  (tmr_wdata),
        .tmr_rdata  (tmr_rdata),
        .tmr_irq    (tmr_irq),
        .task_id    (task_id),
        .preempt    (preempt),
        .tick_count (tick_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    int          m_task;
    logic [31:0] m_ticks;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Round-robin reference: first runnable slot after cur, wrapping; -1 when nothing is runnable.
    function automatic int rr_next(input int cur, input logic [NT-1:0] mask);
        for (int s = 1; s <= NT; s++)
            if (mask[(cur + s) % NT]) return (cur + s) % NT;
        return -1;
    endfunction

    task automatic chk_wr(input string tag, input logic [2:0] addr, input logic [7:0] data);
        chk({tag, "_strb"}, {29'd0, tmr_cs, tmr_write, tmr_read}, 32'b110);
        chk({tag, "_addr"}, {29'd0, tmr_addr}, {29'd0, addr});
        chk({tag, "_data"}, {24'd0, tmr_wdata}, {24'd0, data});
    endtask

    task automatic do_init(input int stop_idx);
        logic [2:0] ea [5];
        logic [7:0] ed [5];
        ea = '{3'd0, 3'd6, 3'd4, 3'd5, 3'd0};
        ed = '{8'h08, PS, TP[7:0], TP[15:8], 8'h07};
        chk("init_idle_busy", {31'd0, busy}, 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_wr($sformatf("init%0d", i), ea[i], ed[i]);
            chk("init_busy", {31'd0, busy}, 32'd1);
            stop = (i == stop_idx);
            @(negedge clk);
        end
        stop = 1'b0;
        if (stop_idx >= 0) begin
            chk_wr("halt", 3'd0, 8'h00);
            chk("halt_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        chk("init_done_busy", {31'd0, busy}, 32'd0);
        chk("init_done_cs", {31'd0, tmr_cs}, 32'd0);
    endtask

    task automatic do_tick(input logic [NT-1:0] mask);
        int nxt;
        task_mask = mask;
        tmr_irq   = 1'b1;
        @(negedge clk);
        chk_wr("ack", 3'd1, 8'h01);
        chk("ack_busy", {31'd0, busy}, 32'd1);
        chk("ack_cnt_hold", tick_count, m_ticks);
        tmr_irq = 1'b0;
        m_ticks = m_ticks + 32'd1;
        nxt     = rr_next(m_task, mask);
        @(negedge clk);
        chk("sched_cnt", tick_count, m_ticks);
        chk("sched_pre", {31'd0, preempt}, 32'd0);
        @(negedge clk);
        if (nxt >= 0) m_task = nxt;
        chk("task_id", {30'd0, task_id}, 32'(m_task));
        chk("preempt", {31'd0, preempt}, (nxt >= 0) ? 32'd1 : 32'd0);
        chk("run_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("preempt_end", {31'd0, preempt}, 32'd0);
    endtask

    // One CPU access while the sequencer is idle (IDLE or RUN with no pending tick).
    task automatic cpu_acc();
        logic rd;
        logic eg;
        rd        = 1'($urandom_range(0, 1));
        eg        = ARB;
        cpu_req   = 1'b1;
        cpu_read  = rd;
        cpu_write = !rd;
        cpu_addr  = 3'($urandom_range(0, 7));
        cpu_wdata = 8'($urandom);
        tmr_rdata = 8'($urandom);
        #1;
        chk("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, eg});
        chk("cpu_strb", {29'd0, tmr_cs, tmr_write, tmr_read}, eg ? {29'd0, 1'b1, !rd, rd} : 32'd0);
        chk("cpu_addr", {29'd0, tmr_addr}, eg ? {29'd0, cpu_addr} : 32'd0);
        chk("cpu_wdata", {24'd0, tmr_wdata}, eg ? {24'd0, cpu_wdata} : 32'd0);
        chk("cpu_rdata", {24'd0, cpu_rdata}, (eg && rd) ? {24'd0, tmr_rdata} : 32'd0);
        @(negedge clk);
        cpu_req  = 1'b0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        m_task = 0; m_ticks = 32'd0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; task_mask = '0;
        cpu_req = 1'b0; cpu_write = 1'b0; cpu_read = 1'b0;
        cpu_addr = 3'd0; cpu_wdata = 8'd0; tmr_rdata = 8'd0; tmr_irq = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_task_id", {30'd0, task_id}, 32'd0);
        chk("rst_preempt", {31'd0, preempt}, 32'd0);
        chk("rst_ticks", tick_count, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cs", {31'd0, tmr_cs}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        cpu_acc();

        do_init(-1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_busy", {31'd0, busy}, 32'd0);
        chk("start_ignored_cs", {31'd0, tmr_cs}, 32'd0);

        for (int i = 0; i < 4; i++) do_tick(4'b1111);
        chk("rr_wrap_task", {30'd0, task_id}, 32'd0);
        chk("rr_wrap_ticks", tick_count, 32'd4);
        for (int i = 0; i < 3; i++) do_tick(4'b0101);
        chk("sparse_task", {30'd0, task_id}, 32'd2);
        do_tick(4'b0000);
        chk("zero_mask_task", {30'd0, task_id}, 32'd2);
        do_tick(4'b0100);

        // CPU read collides with a rising tick: sequencer wins until the tick is dispatched.
        task_mask = 4'b1111; cpu_req = 1'b1; cpu_read = 1'b1; cpu_write = 1'b0;
        cpu_addr = 3'd2; cpu_wdata = 8'h00; tmr_rdata = 8'h5A; tmr_irq = 1'b1;
        #1;
        chk("cont_gnt_irq", {31'd0, cpu_gnt}, 32'd0);
        @(negedge clk);
        chk("cont_gnt_ack", {31'd0, cpu_gnt}, 32'd0);
        chk_wr("cont_ack", 3'd1, 8'h01);
        tmr_irq = 1'b0;
        m_ticks = m_ticks + 32'd1;
        m_task  = rr_next(m_task, 4'b1111);
        @(negedge clk);
        chk("cont_gnt_sched", {31'd0, cpu_gnt}, 32'd0);
        @(negedge clk);
        chk("cont_gnt_run", {31'd0, cpu_gnt}, {31'd0, ARB});
        chk("cont_rdata", {24'd0, cpu_rdata}, ARB ? 32'h5A : 32'd0);
        chk("cont_task", {30'd0, task_id}, 32'(m_task));
        cpu_req = 1'b0; cpu_read = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) cpu_acc();
            else do_tick(4'($urandom_range(0, 15)));
        end

        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk_wr("run_stop", 3'd0, 8'h00);
        @(negedge clk);
        chk("stop_idle_busy", {31'd0, busy}, 32'd0);
        chk("stop_idle_cs", {31'd0, tmr_cs}, 32'd0);
        do_init(2);
        cpu_acc();
        do_init(-1);
        do_tick(4'b1111);
        do_tick(4'b1111);

        // Asynchronous reset while the ACK write is on the port.
        task_mask = 4'b1111;
        tmr_irq = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_task_id", {30'd0, task_id}, 32'd0);
        chk("arst_preempt", {31'd0, preempt}, 32'd0);
        chk("arst_ticks", tick_count, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_cs", {31'd0, tmr_cs}, 32'd0);
        tmr_irq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_task = 0; m_ticks = 32'd0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_cs", {31'd0, tmr_cs}, 32'd0);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        cpu_acc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
